// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks.
//   ps2_state_t  : host transmitter frame states
//   PS2_CMD_*    : common keyboard command bytes and the device ACK byte
//   odd_parity() : parity bit that makes the 9-bit {parity, data} word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser plus falling-edge detector for one PS/2 pad.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (line assumed idle-high)
//   pad     : raw asynchronous pad input
//   level   : synchronised pad level
//   fall    : one-cycle pulse when the synchronised level goes 1 -> 0
module ps2_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], pad};
      prev_q <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign fall  = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte per request:
// inhibit (clock low), start, D0..D7, odd parity, stop, then checks the
// device ACK and waits for the bus to go idle.
//   clk, reset_n              : system clock, asynchronous active-low reset
//   tx_data, tx_valid         : byte to send, accepted when tx_ready is high
//   tx_ready, busy            : ready in IDLE only; busy = !tx_ready
//   done, err                 : one-cycle completion / failure pulses
//   ps2_clk_in, ps2_data_in   : raw pad inputs (asynchronous)
//   ps2_clk_oe, ps2_data_oe   : 1 pulls the open-drain pad low
// Build option: define PS2_TX_RETRY_EN to re-send the latched byte up to
// MAX_RETRIES times after a NACK or timeout before reporting err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 28_000_000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned TIMEOUT_US  = 15_000,
  parameter int unsigned MAX_RETRIES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // 64-bit products: TIMEOUT_US * CLK_HZ overflows 32 bits at the defaults.
  localparam longint unsigned INH_CYC_L = (64'(INHIBIT_US) * 64'(CLK_HZ)) / 64'd1_000_000;
  localparam longint unsigned TO_CYC_L  = (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1_000_000;
  localparam int unsigned     INH_CYC   = 32'(INH_CYC_L);
  localparam int unsigned     TO_CYC    = 32'(TO_CYC_L);
  localparam int unsigned     TMR_MAX   = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int unsigned     TMR_W     = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INH_CYC - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TO_CYC - 1);

  localparam logic [3:0] EDGE_PARITY = 4'd9;
  localparam logic [3:0] EDGE_STOP   = 4'd10;
  localparam logic [3:0] EDGE_ACK    = 4'd11;

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  ps2_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [8:0]       shreg_q, shreg_d;
  logic             cur_bit_q, cur_bit_d;
  logic             ack_q, ack_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fail, timeout_hit;

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pad     (ps2_clk_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pad     (ps2_data_in),
    .level   (data_lvl),
    .fall    (data_fall_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '1;
      cur_bit_q <= 1'b1;
      ack_q     <= 1'b1;
      data_q    <= '0;
      parity_q  <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      cur_bit_q <= cur_bit_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign bit_cnt_inc = (bit_cnt_q >= EDGE_ACK) ? EDGE_ACK : bit_cnt_q + 4'd1;

  // Next-state logic. The timeout check sits ahead of edge handling so a
  // clock edge landing on the expiry cycle is discarded.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cur_bit_d   = cur_bit_q;
    ack_d       = ack_q;
    data_d      = data_q;
    parity_d    = parity_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d     = retry_q;
`endif
    timeout_hit = (state_q inside {START, BITS, STOP, ACK, WAIT_IDLE}) &&
                  (timer_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = odd_parity(tx_data);
          timer_d  = '0;
          state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      INHIBIT: begin
        if (timer_q == INH_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          shreg_d   = {parity_q, data_q};
          state_d   = START;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = timer_q + 1'b1;
        if (timeout_hit) begin
          fail = 1'b1;
        end else begin
          case (state_q)
            START: begin
              if (clk_fall) begin
                cur_bit_d = shreg_q[0];
                shreg_d   = {1'b1, shreg_q[8:1]};
                bit_cnt_d = bit_cnt_inc;
                state_d   = BITS;
              end
            end
            BITS: begin
              if (clk_fall) begin
                bit_cnt_d = bit_cnt_inc;
                if (bit_cnt_q == EDGE_PARITY) begin
                  state_d = STOP;
                end else begin
                  cur_bit_d = shreg_q[0];
                  shreg_d   = {1'b1, shreg_q[8:1]};
                end
              end
            end
            STOP: begin
              if (clk_fall) begin
                ack_d     = data_lvl;
                bit_cnt_d = bit_cnt_inc;
                state_d   = ACK;
              end
            end
            ACK: begin
              if (ack_q) begin
                fail = 1'b1;
              end else begin
                state_d = WAIT_IDLE;
              end
            end
            WAIT_IDLE: begin
              if (clk_lvl && data_lvl) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (fail) begin
      timer_d   = '0;
      bit_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + 1'b1;
        state_d = INHIBIT;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
`else
      err_d   = 1'b1;
      state_d = IDLE;
`endif
    end
  end

  // Pad drivers are decoded from registered state, so an asynchronous
  // reset releases both lines without waiting for a clock.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (timer_q == INH_LAST);
      end
      START:   ps2_data_oe = 1'b1;
      BITS:    ps2_data_oe = ~cur_bit_q;
      default: ;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  // Scaled timing: 1 MHz clock gives 120 inhibit cycles and 3000 timeout cycles.
  localparam int unsigned T_CLK_HZ  = 1_000_000;
  localparam int unsigned T_INH_US  = 120;
  localparam int unsigned T_TO_US   = 3000;
  localparam int unsigned T_RETRIES = 2;
  localparam int INH  = 120;
  localparam int TO   = 3000;
  localparam int HALF = 30;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;

  // Open-drain bus: low if either side pulls.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_HZ      (T_CLK_HZ),
    .INHIBIT_US  (T_INH_US),
    .TIMEOUT_US  (T_TO_US),
    .MAX_RETRIES (T_RETRIES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Bus monitor: inhibit run length, data-low point within inhibit,
  // release times and done/err pulses.
  int unsigned cyc = 0, run = 0, data_at = 0, last_run = 0, last_data_at = 0;
  int unsigned phases = 0, last_rel = 0, err_cyc = 0;
  int unsigned done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [1:0]  oe_at_err = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      run <= run + 1;
      if (ps2_data_oe && data_at == 0) data_at <= run + 1;
    end else begin
      if (run != 0) begin
        last_run     <= run;
        last_data_at <= data_at;
        phases       <= phases + 1;
        last_rel     <= cyc;
      end
      run     <= 0;
      data_at <= 0;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt   <= err_cnt + 1;
      err_cyc   <= cyc;
      oe_at_err <= {ps2_clk_oe, ps2_data_oe};
    end
    if (done && err) both_cnt <= both_cnt + 1;
  end

  // Reference model: frame as the device sees it, and the expected outcome
  // for a device that NACKs the first `nacks` attempts.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  typedef struct {
    logic [7:0]  data;
    int          nacks;
    logic [10:0] exp_frame;
    int          exp_phases;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t make_vec(input logic [7:0] b, input int nacks);
    vec_t v;
    v.data      = b;
    v.nacks     = nacks;
    v.exp_frame = model_frame(b);
    if (nacks >= ATTEMPTS) begin
      v.exp_phases = ATTEMPTS; v.exp_done = 0; v.exp_err = 1;
    end else begin
      v.exp_phases = nacks + 1; v.exp_done = 1; v.exp_err = 0;
    end
    return v;
  endfunction

  task automatic settle();
    int n = 0;
    dev_clk = 1'b1; dev_data = 1'b1; tx_valid = 1'b0;
    while ((!tx_ready || ps2_clk_oe) && n < 4 * (TO + INH)) begin
      @(negedge clk); n++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 4 * (TO + INH)) begin
      @(negedge clk); n++;
    end
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", tx_ready, 0);
    // A competing request during the frame must be ignored.
    tx_data = ~b; tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side of one attempt: wait for inhibit and release, clock out
  // start..stop sampling on rising edges, then ACK (data low) or NACK.
  task automatic dev_frame(input bit ack, output logic [10:0] seen, output bit ok);
    int n;
    ok = 1'b1; seen = '1;
    n = 0;
    while (!ps2_clk_oe && n < 4 * (TO + INH)) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) begin ok = 1'b0; return; end
    n = 0;
    while (ps2_clk_oe && n < 2 * INH) begin @(negedge clk); n++; end
    if (ps2_clk_oe) begin ok = 1'b0; return; end
    repeat (HALF) @(negedge clk);
    seen[0] = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      seen[k] = ps2_data_in;
      repeat (HALF) @(negedge clk);
    end
    dev_data = ~ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic run_vector(input vec_t v);
    int unsigned bd, be, bp;
    logic [10:0] seen, got;
    bit ok, all_ok;
    int n;
    settle();
    bd = done_cnt; be = err_cnt; bp = phases;
    got = '0; all_ok = 1'b1;
    send(v.data);
    for (int a = 0; a < v.exp_phases; a++) begin
      dev_frame(a >= v.nacks, seen, ok);
      all_ok &= ok;
      if (a == 0 || got == v.exp_frame) got = seen;
    end
    n = 0;
    while (done_cnt == bd && err_cnt == be && n < 2 * (TO + INH)) begin
      @(negedge clk); n++;
    end
    repeat (20) @(negedge clk);
    check("device_handshake", all_ok, 1);
    check("frame_bits", got, v.exp_frame);
    check("done_pulses", done_cnt - bd, v.exp_done);
    check("err_pulses", err_cnt - be, v.exp_err);
    check("inhibit_phases", phases - bp, v.exp_phases);
    check("inhibit_cycles", last_run, INH);
    check("data_low_in_inhibit", last_data_at, INH);
    check("ready_after_frame", tx_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned bd, be, bp;
    int n;

    reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    vecs.push_back(make_vec(PS2_CMD_SET_LEDS, 0));
    vecs.push_back(make_vec(8'h00, 0));
    vecs.push_back(make_vec(8'h01, 0));
    vecs.push_back(make_vec(PS2_CMD_RESET, 0));
    vecs.push_back(make_vec(8'hAA, 1));
    vecs.push_back(make_vec(8'h55, 2));
    vecs.push_back(make_vec(8'h3C, 3));
    for (int i = 0; i < 8; i++)
      vecs.push_back(make_vec(8'($urandom_range(255, 0)), int'($urandom_range(1, 0))));

    foreach (vecs[i]) run_vector(vecs[i]);

    // Silent device: err must follow the last clock release by the timeout.
    settle();
    bd = done_cnt; be = err_cnt; bp = phases;
    send(8'hA5);
    n = 0;
    while (err_cnt == be && n < ATTEMPTS * (TO + INH) + 200) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("timeout_err_pulses", err_cnt - be, 1);
    check("timeout_done_pulses", done_cnt - bd, 0);
    check("timeout_latency", err_cyc - last_rel, TO);
    check("timeout_oes_released", oe_at_err, 0);
    check("timeout_phases", phases - bp, ATTEMPTS);

    // Reset in the low phase after falling edge 5 (bit 4 of 0x0F is 0, so data is pulled).
    settle();
    send(8'h0F);
    n = 0;
    while (!ps2_clk_oe && n < 2 * INH) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_oe && n < 2 * INH) begin @(negedge clk); n++; end
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k < 5) begin
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    check("bit4_driven_before_reset", ps2_data_oe, 1);
    bd = done_cnt; be = err_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_clk_oe", ps2_clk_oe, 0);
    check("reset_mid_data_oe", ps2_data_oe, 0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);
    check("busy_after_reset", busy, 0);
    repeat (10) @(negedge clk);
    check("reset_no_done", done_cnt - bd, 0);
    check("reset_no_err", err_cnt - be, 0);
    run_vector(make_vec(PS2_CMD_ENABLE, 0));

    check("done_err_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
